// File: rtl/spi_ram_arbiter_if.sv
// Signal bundle for spi_ram_arbiter: SPI command/response, host request port
// and the single-port RAM side. The slave modport is the arbiter's view.
interface spi_ram_arbiter_if #(
  parameter int ADDR_SIZE = 8
);
  logic [9:0]           spi_rx_data;
  logic                 spi_rx_valid;
  logic [7:0]           spi_tx_data;
  logic                 spi_tx_valid;
  logic                 host_req;
  logic                 host_we;
  logic [ADDR_SIZE-1:0] host_addr;
  logic [7:0]           host_wdata;
  logic                 host_gnt;
  logic [7:0]           host_rdata;
  logic                 host_rvalid;
  logic                 ram_en;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [7:0]           ram_wdata;
  logic [7:0]           ram_rdata;
  logic                 spi_ovf;

  modport slave (
    input  spi_rx_data, spi_rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
    output spi_tx_data, spi_tx_valid, host_gnt, host_rdata, host_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
  );

  modport master (
    output spi_rx_data, spi_rx_valid, host_req, host_we, host_addr, host_wdata, ram_rdata,
    input  spi_tx_data, spi_tx_valid, host_gnt, host_rdata, host_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between an SPI command
// stream (one pending access slot) and a level-requesting host port.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8
) (
  input logic              clk,
  input logic              rst,
  spi_ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_SPI  = 2'd1,
    GNT_HOST = 2'd2,
    RD_RET   = 2'd3
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [ADDR_SIZE-1:0] wr_addr_r, rd_addr_r, host_addr_r;
  logic [7:0]           spi_wdata_r, host_wdata_r, spi_tx_data_r, host_rdata_r;
  logic                 spi_pend_r, spi_rd_r, spi_ovf_r, spi_last_r;
  logic                 srv_host_r, host_we_r, spi_tx_valid_r, host_rvalid_r;
  logic                 spi_acc_s, ram_en_s, ram_we_s, host_gnt_s;
  logic [ADDR_SIZE-1:0] ram_addr_s;
  logic [7:0]           ram_wdata_s;

  // Opcodes 01 and 11 both have bit 8 set: they are the RAM-access commands.
  assign spi_acc_s = bus.spi_rx_valid & bus.spi_rx_data[8];

  // SPI command decode: address registers and the single pending-access slot
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_r   <= '0;
      rd_addr_r   <= '0;
      spi_wdata_r <= 8'h00;
      spi_pend_r  <= 1'b0;
      spi_rd_r    <= 1'b0;
      spi_ovf_r   <= 1'b0;
    end else begin
      if (bus.spi_rx_valid) begin
        case (bus.spi_rx_data[9:8])
          2'b00:   wr_addr_r   <= ADDR_SIZE'(bus.spi_rx_data[7:0]);
          2'b01:   spi_wdata_r <= bus.spi_rx_data[7:0];
          2'b10:   rd_addr_r   <= ADDR_SIZE'(bus.spi_rx_data[7:0]);
          default: ;
        endcase
      end
      if (spi_acc_s) begin
        spi_pend_r <= 1'b1;
        spi_rd_r   <= bus.spi_rx_data[9];
        if (spi_pend_r) begin
          spi_ovf_r <= 1'b1;
        end
      end else if (state_r == GNT_SPI) begin
        spi_pend_r <= 1'b0;
      end
    end
  end

  // Next-state: arbitration in IDLE, reads detour through RD_RET
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (spi_pend_r && bus.host_req) begin
          if (spi_last_r) begin
            state_nxt_s = GNT_HOST;
          end else begin
            state_nxt_s = GNT_SPI;
          end
        end else if (spi_pend_r) begin
          state_nxt_s = GNT_SPI;
        end else if (bus.host_req) begin
          state_nxt_s = GNT_HOST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_SPI: begin
        if (spi_rd_r) begin
          state_nxt_s = RD_RET;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_HOST: begin
        if (host_we_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_RET;
        end
      end
      RD_RET:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, round-robin pointer, host field latch and read-data return
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      spi_last_r     <= 1'b0;
      srv_host_r     <= 1'b0;
      host_we_r      <= 1'b0;
      host_addr_r    <= '0;
      host_wdata_r   <= 8'h00;
      spi_tx_data_r  <= 8'h00;
      host_rdata_r   <= 8'h00;
      spi_tx_valid_r <= 1'b0;
      host_rvalid_r  <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      spi_tx_valid_r <= 1'b0;
      host_rvalid_r  <= 1'b0;
      if (state_r == IDLE && state_nxt_s == GNT_HOST) begin
        host_we_r    <= bus.host_we;
        host_addr_r  <= bus.host_addr;
        host_wdata_r <= bus.host_wdata;
        srv_host_r   <= 1'b1;
        spi_last_r   <= 1'b0;
      end else if (state_r == IDLE && state_nxt_s == GNT_SPI) begin
        srv_host_r   <= 1'b0;
        spi_last_r   <= 1'b1;
      end
      if (state_r == RD_RET) begin
        if (srv_host_r) begin
          host_rdata_r  <= bus.ram_rdata;
          host_rvalid_r <= 1'b1;
        end else begin
          spi_tx_data_r  <= bus.ram_rdata;
          spi_tx_valid_r <= 1'b1;
        end
      end
    end
  end

  // RAM strobe and fields are a pure decode of the grant state
  always_comb begin
    ram_en_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = '0;
    ram_wdata_s = 8'h00;
    host_gnt_s  = 1'b0;
    case (state_r)
      GNT_SPI: begin
        ram_en_s    = 1'b1;
        ram_we_s    = ~spi_rd_r;
        ram_addr_s  = spi_rd_r ? rd_addr_r : wr_addr_r;
        ram_wdata_s = spi_wdata_r;
      end
      GNT_HOST: begin
        ram_en_s    = 1'b1;
        ram_we_s    = host_we_r;
        ram_addr_s  = host_addr_r;
        ram_wdata_s = host_wdata_r;
        host_gnt_s  = 1'b1;
      end
      default: ;
    endcase
  end

  // Single-bit outputs are forced low for as long as reset is high.
  assign bus.ram_en       = ram_en_s & ~rst;
  assign bus.ram_we       = ram_we_s & ~rst;
  assign bus.host_gnt     = host_gnt_s & ~rst;
  assign bus.spi_tx_valid = spi_tx_valid_r & ~rst;
  assign bus.host_rvalid  = host_rvalid_r & ~rst;
  assign bus.spi_ovf      = spi_ovf_r & ~rst;
  assign bus.ram_addr     = ram_addr_s;
  assign bus.ram_wdata    = ram_wdata_s;
  assign bus.spi_tx_data  = spi_tx_data_r;
  assign bus.host_rdata   = host_rdata_r;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: a transaction-order model of expected RAM
// accesses and read returns, checked every cycle, plus literal timing/data pins.
module tb_spi_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  typedef struct {
    logic       host;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t       acc_q[$];
  logic [7:0] spi_rd_q[$];
  logic [7:0] host_rd_q[$];
  logic [7:0] ram[0:255];
  logic [7:0] exp_mem[0:255];
  logic [7:0] exp_wr = 8'h00;
  logic [7:0] exp_rd = 8'h00;
  logic       exp_ovf = 1'b0;

  spi_ram_arbiter_if #(.ADDR_SIZE(8)) bus ();
  spi_ram_arbiter #(.ADDR_SIZE(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural single-port RAM: read data appears the cycle after the access
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void exp_spi_write(input logic [7:0] d);
    acc_q.push_back('{host: 1'b0, we: 1'b1, addr: exp_wr, data: d});
    exp_mem[exp_wr] = d;
  endfunction

  function automatic void exp_spi_read();
    acc_q.push_back('{host: 1'b0, we: 1'b0, addr: exp_rd, data: 8'h00});
    spi_rd_q.push_back(exp_mem[exp_rd]);
  endfunction

  function automatic void exp_host_write(input logic [7:0] a, input logic [7:0] d);
    acc_q.push_back('{host: 1'b1, we: 1'b1, addr: a, data: d});
    exp_mem[a] = d;
  endfunction

  function automatic void exp_host_read(input logic [7:0] a, input bit returns);
    acc_q.push_back('{host: 1'b1, we: 1'b0, addr: a, data: 8'h00});
    if (returns) host_rd_q.push_back(exp_mem[a]);
  endfunction

  // Compare process: every cycle, DUT outputs against the expected streams
  always @(negedge clk) begin
    acc_t a;
    #1;
    if (rst) begin
      chk("reset_outputs_low", 32'({bus.spi_tx_valid, bus.host_gnt, bus.host_rvalid,
                                    bus.ram_en, bus.ram_we, bus.spi_ovf}), 32'd0);
    end else begin
      chk("spi_ovf", 32'(bus.spi_ovf), 32'(exp_ovf));
      if (bus.ram_en) begin
        if (acc_q.size() == 0) begin
          chk("ram_en_unexpected", 32'(bus.ram_en), 32'd0);
        end else begin
          a = acc_q.pop_front();
          chk("ram_we", 32'(bus.ram_we), 32'(a.we));
          chk("ram_addr", 32'(bus.ram_addr), 32'(a.addr));
          if (a.we) chk("ram_wdata", 32'(bus.ram_wdata), 32'(a.data));
          chk("host_gnt_winner", 32'(bus.host_gnt), 32'(a.host));
        end
      end else begin
        chk("host_gnt_without_access", 32'(bus.host_gnt), 32'd0);
      end
      if (bus.spi_tx_valid) begin
        if (spi_rd_q.size() == 0) chk("spi_tx_valid_unexpected", 32'(bus.spi_tx_valid), 32'd0);
        else chk("spi_tx_data", 32'(bus.spi_tx_data), 32'(spi_rd_q.pop_front()));
      end
      if (bus.host_rvalid) begin
        if (host_rd_q.size() == 0) chk("host_rvalid_unexpected", 32'(bus.host_rvalid), 32'd0);
        else chk("host_rdata", 32'(bus.host_rdata), 32'(host_rd_q.pop_front()));
      end
    end
  end

  task automatic spi_cmd(input logic [1:0] op, input logic [7:0] pl);
    bus.spi_rx_data  = {op, pl};
    bus.spi_rx_valid = 1'b1;
    if (op == 2'b00) exp_wr = pl;
    else if (op == 2'b10) exp_rd = pl;
    @(negedge clk);
    bus.spi_rx_valid = 1'b0;
  endtask

  task automatic host_access(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                             output int lat);
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
    bus.host_req   = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.host_gnt && lat < 20);
    bus.host_req = 1'b0;
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    while (!bus.spi_tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_hrv(output int n);
    n = 0;
    while (!bus.host_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_ovf = 1'b0;
    exp_wr = 8'h00;
    exp_rd = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    bus.spi_rx_data = 10'h000;
    bus.spi_rx_valid = 1'b0;
    bus.host_req = 1'b0;
    bus.host_we = 1'b0;
    bus.host_addr = 8'h00;
    bus.host_wdata = 8'h00;
    bus.ram_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_spi_tx_data", 32'(bus.spi_tx_data), 32'h00);
    chk("reset_host_rdata", 32'(bus.host_rdata), 32'h00);

    // SPI write 0xA5 to 0x12, then read it back with cycle-0..4 timing
    spi_cmd(2'b00, 8'h12);
    exp_spi_write(8'hA5);
    spi_cmd(2'b01, 8'hA5);
    repeat (4) @(negedge clk);
    spi_cmd(2'b10, 8'h12);
    exp_spi_read();
    spi_cmd(2'b11, 8'h00);
    wait_tx(n);
    chk("spi_read_latency", 32'(1 + n), 32'd4);
    chk("spi_read_value", 32'(bus.spi_tx_data), 32'hA5);
    chk("ram_0x12", 32'(ram[8'h12]), 32'hA5);
    @(negedge clk);

    // Host write then read of 0x40
    exp_host_write(8'h40, 8'h3C);
    host_access(1'b1, 8'h40, 8'h3C, lat);
    chk("host_wr_gnt_latency", 32'(lat), 32'd1);
    @(negedge clk);
    exp_host_read(8'h40, 1'b1);
    host_access(1'b0, 8'h40, 8'h00, lat);
    chk("host_rd_gnt_latency", 32'(lat), 32'd1);
    wait_hrv(n);
    chk("host_rvalid_latency", 32'(n), 32'd2);
    chk("host_read_value", 32'(bus.host_rdata), 32'h3C);
    @(negedge clk);

    // Round-robin ties from reset: SPI, host, SPI, host; then SPI-last tie goes to host
    do_reset();
    chk("reset_clears_spi_tx_data", 32'(bus.spi_tx_data), 32'h00);
    spi_cmd(2'b00, 8'h20);
    exp_spi_write(8'h11);
    exp_host_write(8'h21, 8'h22);
    exp_spi_write(8'h33);
    exp_host_write(8'h22, 8'h44);
    exp_spi_write(8'h55);
    exp_host_write(8'h23, 8'h77);
    exp_spi_write(8'h66);
    spi_cmd(2'b01, 8'h11);
    host_access(1'b1, 8'h21, 8'h22, lat);
    chk("tie1_host_waits", 32'(lat), 32'd3);
    spi_cmd(2'b01, 8'h33);
    host_access(1'b1, 8'h22, 8'h44, lat);
    chk("tie2_host_waits", 32'(lat), 32'd3);
    spi_cmd(2'b01, 8'h55);
    repeat (3) @(negedge clk);
    spi_cmd(2'b01, 8'h66);
    host_access(1'b1, 8'h23, 8'h77, lat);
    chk("tie3_host_wins", 32'(lat), 32'd1);
    repeat (4) @(negedge clk);
    chk("ram_0x20_last", 32'(ram[8'h20]), 32'h66);
    chk("ram_0x22", 32'(ram[8'h22]), 32'h44);

    // Two SPI writes back to back while the host read holds the RAM
    exp_host_read(8'h40, 1'b1);
    exp_spi_write(8'hB2);
    host_access(1'b0, 8'h40, 8'h00, lat);
    spi_cmd(2'b01, 8'hB1);
    spi_cmd(2'b01, 8'hB2);
    exp_ovf = 1'b1;
    repeat (6) @(negedge clk);
    chk("ovf_sticky", 32'(bus.spi_ovf), 32'd1);
    chk("ram_0x20_overwrite", 32'(ram[8'h20]), 32'hB2);
    do_reset();
    chk("ovf_cleared_by_reset", 32'(bus.spi_ovf), 32'd0);

    // Reset during RD_RET of a host read discards the return
    exp_host_read(8'h40, 1'b0);
    host_access(1'b0, 8'h40, 8'h00, lat);
    @(negedge clk);
    do_reset();
    chk("rdret_reset_host_rdata", 32'(bus.host_rdata), 32'h00);
    repeat (3) @(negedge clk);
    exp_host_write(8'h41, 8'h5A);
    host_access(1'b1, 8'h41, 8'h5A, lat);
    chk("post_reset_wr_gnt", 32'(lat), 32'd1);
    @(negedge clk);
    exp_host_read(8'h41, 1'b1);
    host_access(1'b0, 8'h41, 8'h00, lat);
    chk("post_reset_rd_gnt", 32'(lat), 32'd1);
    wait_hrv(n);
    chk("post_reset_rd_value", 32'(bus.host_rdata), 32'h5A);

    repeat (5) @(negedge clk);
    chk("no_access_lost", 32'(acc_q.size()), 32'd0);
    chk("no_spi_return_lost", 32'(spi_rd_q.size()), 32'd0);
    chk("no_host_return_lost", 32'(host_rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
